fir_filter_tdm: RTL and testbench
=================================

// Module: fir_filter_tdm
// PURPOSE
//  Parametrised time-multiplexed FIR: one shared MAC, NUM_TAPS cycles per output sample.
//  Runtime-writable coefficient bank; valid/ready sample input; one-cycle out_valid strobe.
//  Sits between the sample source and downstream decimation/post-processing in the DSP chain.
// PARAMETERS
//  DATA_W    4   signed input sample width
//  COEF_W    8   signed coefficient width
//  NUM_TAPS  71  filter length (>=2)
//  ADDR_W    7   coefficient address width, 2**ADDR_W >= NUM_TAPS
//  OUT_W     12  signed output width
//  ACC_W (localparam) = DATA_W+COEF_W+$clog2(NUM_TAPS), full-precision accumulator
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  sample_in    in   DATA_W   signed input sample
//  in_valid     in   1        sample_in valid
//  in_ready     out  1        block can accept a sample
//  coeff_write  in   1        coefficient write strobe
//  coeff_addr   in   ADDR_W   tap index of write
//  coeff_in     in   COEF_W   signed coefficient value
//  fir_out      out  OUT_W    signed filter output, held between strobes
//  out_valid    out  1        one-cycle strobe: fir_out updated
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, fir_out=0, acc=0, wr_ptr=0,
//   delay line and coefficient bank all zero. Reset mid-MAC aborts; no output.
//  FSM IDLE -> MAC -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&in_ready at edge T: x stored at delay[wr_ptr],
//         tap k=0, acc=0, -> MAC. No handshake: stay IDLE.
//   MAC:  in_ready=0. Each cycle acc += coeff[k]*delay[(wr_ptr-k) mod NUM_TAPS];
//         k==NUM_TAPS-1 -> DONE, fir_out<=convert(final acc), out_valid<=1.
//   DONE: in_ready=0, out_valid=1 for exactly this cycle; wr_ptr advances
//         (wraps NUM_TAPS-1 -> 0); -> IDLE.
//  Latency: out_valid high NUM_TAPS+1 cycles after accept edge; throughput
//   one sample per NUM_TAPS+2 cycles. in_valid outside IDLE is ignored (held by source).
//  Arithmetic: products DATA_W+COEF_W signed, sign-extended to ACC_W; acc never overflows.
//  Coefficient writes: accepted any state, take effect next cycle; a write during MAC
//   affects only taps not yet read. coeff_addr >= NUM_TAPS: write ignored.
//  Same-cycle write and read of one tap: MAC uses old value.
//  Delay line is circular over NUM_TAPS; oldest sample overwritten on wrap.
// CONFIGURATION
//  FIR_SAT_EN defined: convert = clamp acc to [-2**(OUT_W-1), 2**(OUT_W-1)-1].
//  FIR_SAT_EN undefined: convert = acc[OUT_W-1:0] (two's-complement wrap).
// STRUCTURE
//  fir_pkg: state enum (IDLE/MAC/DONE), ACC_W/tap-index width functions, sat helper.
//  Sub-module fir_coeff_bank: NUM_TAPS x COEF_W regs, async-reset, 1 write port,
//   1 combinational read port (old-value-on-collision). Top holds FSM, delay line, MAC.
// TESTING (defaults, coeff[k]=k written k=0..70, outputs counted from first accept)
//  Impulse: 1 then 70 zeros -> output n = n (0,1,..,70), then 0.
//  Step: 1 held 71+ samples -> n(n+1)/2 until 2485; wrap build 2485 -> -1611,
//   FIR_SAT_EN build -> 2047.
//  Neg impulse/step: -1 -> -n; steady -2485 -> wrap 1611, sat -2048.
//  Handshake: in_valid held high -> accepts exactly every 73 cycles; out_valid 1 cycle,
//   72 cycles after each accept edge; in_ready low throughout MAC/DONE.
//  Coefficient hazards: write coeff[70]=0 mid-MAC at k=10 -> steady step 2415;
//   write addr 100 -> no effect.
//  Async rst during MAC -> outputs/zeroed immediately; no out_valid; next impulse
//   reproduces all-zero response until coefficients rewritten.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR (fir_filter_tdm).
// Holds the FSM state enum, width helpers and the output saturation helper.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int tap_width(input int num_taps);
      return (num_taps > 1) ? $clog2(num_taps) : 1;
   endfunction

   // Accumulator wide enough that NUM_TAPS full-scale products cannot overflow.
   function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
      return data_w + coef_w + $clog2(num_taps);
   endfunction

   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                    input int out_w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fir_filter_tdm_coeff_bank.sv
// Coefficient register bank for fir_filter_tdm: one write port, one combinational
// read port that returns the pre-write value when read and write hit the same tap.
module fir_coeff_bank
   import fir_pkg::*;
#(
   parameter int COEF_W   = 8,
   parameter int NUM_TAPS = 71,
   parameter int ADDR_W   = 7,
   parameter int TAP_W    = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [COEF_W-1:0] wr_data,
   input  logic [TAP_W-1:0]         rd_addr,
   output logic signed [COEF_W-1:0] rd_data
);

   logic signed [COEF_W-1:0] coeff_q [NUM_TAPS];
   logic signed [COEF_W-1:0] coeff_d [NUM_TAPS];

   // Out-of-range addresses match no tap and are dropped.
   always_comb begin
      coeff_d = coeff_q;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (wr_en && (int'(wr_addr) == i)) coeff_d[i] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) coeff_q <= '{default: '0};
      else     coeff_q <= coeff_d;
   end

   assign rd_data = coeff_q[rd_addr];

endmodule

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR: one shared MAC, NUM_TAPS cycles per output sample.
// Build option: define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_filter_tdm
   import fir_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int COEF_W   = 8,
   parameter int NUM_TAPS = 71,
   parameter int ADDR_W   = 7,
   parameter int OUT_W    = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     coeff_write,
   input  logic [ADDR_W-1:0]        coeff_addr,
   input  logic signed [COEF_W-1:0] coeff_in,
   output logic signed [OUT_W-1:0]  fir_out,
   output logic                     out_valid
);

   localparam int ACC_W  = acc_width(DATA_W, COEF_W, NUM_TAPS);
   localparam int TAP_W  = tap_width(NUM_TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [TAP_W-1:0] LAST_K = TAP_W'(NUM_TAPS - 1);
   localparam logic [TAP_W-1:0] N_TAPS = TAP_W'(NUM_TAPS);

   state_e                    state_q, state_d;
   logic [TAP_W-1:0]          k_q, k_d;
   logic [TAP_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [OUT_W-1:0]   fir_out_q, fir_out_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0]  delay_q [NUM_TAPS];
   logic signed [DATA_W-1:0]  delay_d [NUM_TAPS];

   logic [TAP_W-1:0]          rd_idx;
   logic signed [COEF_W-1:0]  coeff_rd;
   logic signed [DATA_W-1:0]  delay_rd;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_sum;

   function automatic logic signed [OUT_W-1:0] convert(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
      logic signed [63:0] c;
      c = sat_clamp(64'(a), OUT_W);
      return c[OUT_W-1:0];
`else
      return a[OUT_W-1:0];
`endif
   endfunction

   fir_coeff_bank #(
      .COEF_W   (COEF_W),
      .NUM_TAPS (NUM_TAPS),
      .ADDR_W   (ADDR_W),
      .TAP_W    (TAP_W)
   ) u_coeff_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (coeff_write),
      .wr_addr (coeff_addr),
      .wr_data (coeff_in),
      .rd_addr (k_q),
      .rd_data (coeff_rd)
   );

   // Newest sample sits at wr_ptr; tap k reads k samples back, modulo the line length.
   always_comb begin
      if (wr_ptr_q >= k_q) rd_idx = wr_ptr_q - k_q;
      else                 rd_idx = wr_ptr_q + N_TAPS - k_q;
   end

   assign delay_rd = delay_q[rd_idx];
   assign prod     = PROD_W'(coeff_rd) * PROD_W'(delay_rd);
   assign acc_sum  = acc_q + ACC_W'(prod);

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      wr_ptr_d    = wr_ptr_q;
      acc_d       = acc_q;
      fir_out_d   = fir_out_q;
      out_valid_d = 1'b0;
      delay_d     = delay_q;
      in_ready    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               delay_d[wr_ptr_q] = sample_in;
               k_d               = '0;
               acc_d             = '0;
               state_d           = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            if (k_q == LAST_K) begin
               fir_out_d   = convert(acc_sum);
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               k_d = k_q + TAP_W'(1);
            end
         end
         DONE: begin
            wr_ptr_d = (wr_ptr_q == LAST_K) ? '0 : wr_ptr_q + TAP_W'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         wr_ptr_q    <= '0;
         acc_q       <= '0;
         fir_out_q   <= '0;
         out_valid_q <= 1'b0;
         delay_q     <= '{default: '0};
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         wr_ptr_q    <= wr_ptr_d;
         acc_q       <= acc_d;
         fir_out_q   <= fir_out_d;
         out_valid_q <= out_valid_d;
         delay_q     <= delay_d;
      end
   end

   assign fir_out   = fir_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed self-checking bench for fir_filter_tdm with a queue scoreboard.
// Honours FIR_SAT_EN for the expected output conversion.
module tb_fir_filter_tdm;

   localparam int DATA_W   = 4;
   localparam int COEF_W   = 8;
   localparam int NUM_TAPS = 71;
   localparam int ADDR_W   = 7;
   localparam int OUT_W    = 12;
   localparam int LAT      = NUM_TAPS + 1;
   localparam int PERIOD   = NUM_TAPS + 2;
`ifdef FIR_SAT_EN
   localparam int STEP_POS = 2047;
   localparam int STEP_NEG = -2048;
   localparam int HAZ_EXP  = 2047;
`else
   localparam int STEP_POS = -1611;
   localparam int STEP_NEG = 1611;
   localparam int HAZ_EXP  = -1681;
`endif

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic signed [DATA_W-1:0] sample_in = '0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic                     coeff_write = 1'b0;
   logic [ADDR_W-1:0]        coeff_addr = '0;
   logic signed [COEF_W-1:0] coeff_in = '0;
   logic signed [OUT_W-1:0]  fir_out;
   logic                     out_valid;

   fir_filter_tdm #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS),
      .ADDR_W(ADDR_W), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .in_valid(in_valid),
      .in_ready(in_ready), .coeff_write(coeff_write), .coeff_addr(coeff_addr),
      .coeff_in(coeff_in), .fir_out(fir_out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int exp_q[$];
   int lat_q[$];
   int acc_cyc[$];
   int coef_m [NUM_TAPS];
   int hist [NUM_TAPS];
   int hp = 0;
   bit accepted;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int conv(input int a);
`ifdef FIR_SAT_EN
      if (a > 2047) return 2047;
      if (a < -2048) return -2048;
      return a;
`else
      int v;
      v = a & 12'hFFF;
      return (v >= 2048) ? v - 4096 : v;
`endif
   endfunction

   // Reference convolution over the last NUM_TAPS samples, newest at tap 0.
   function automatic int model_push(input int x);
      int s;
      hist[hp] = x;
      s = 0;
      for (int k = 0; k < NUM_TAPS; k++)
         s += coef_m[k] * hist[(hp - k + NUM_TAPS) % NUM_TAPS];
      hp = (hp + 1) % NUM_TAPS;
      return conv(s);
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NUM_TAPS; k++) begin
         coef_m[k] = 0;
         hist[k] = 0;
      end
      hp = 0;
   endfunction

   // One clock: register a handshake about to occur, then sample outputs mid-cycle.
   task automatic step();
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
         accepted = 1'b1;
         acc_cyc.push_back(cyc);
         lat_q.push_back(cyc);
         exp_q.push_back(model_push(int'(sample_in)));
      end
      @(negedge clk);
      cyc++;
      if (out_valid === 1'b1) begin
         chk("ready_low_in_done", {31'b0, in_ready}, 0);
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", {31'b0, out_valid}, 0);
         end else begin
            chk("fir_out", fir_out, exp_q.pop_front());
            chk("latency", cyc - lat_q.pop_front(), LAT);
         end
      end
   endtask

   task automatic send_nowait(input int x);
      sample_in = DATA_W'(x);
      in_valid = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 2 * PERIOD && !accepted; i++) step();
      in_valid = 1'b0;
      if (!accepted) chk("accept_timeout", 1, 0);
   endtask

   task automatic wait_out();
      for (int i = 0; i < 2 * PERIOD && exp_q.size() != 0; i++) step();
      if (exp_q.size() != 0) begin
         chk("output_timeout", exp_q.size(), 0);
         exp_q.delete();
         lat_q.delete();
      end
   endtask

   task automatic send(input int x);
      send_nowait(x);
      wait_out();
   endtask

   task automatic wcoef(input int addr, input int val);
      coeff_write = 1'b1;
      coeff_addr = ADDR_W'(addr);
      coeff_in = COEF_W'(val);
      step();
      coeff_write = 1'b0;
      if (addr < NUM_TAPS) coef_m[addr] = val;
   endtask

   initial begin
      int rdy;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_fir_out", fir_out, 0);
      rst = 1'b0;
      step();

      for (int k = 0; k < NUM_TAPS; k++) wcoef(k, k);

      send(1);
      chk("impulse_n0", fir_out, 0);
      for (int n = 1; n <= NUM_TAPS + 1; n++) send(0);
      chk("impulse_tail", fir_out, 0);

      for (int n = 0; n < NUM_TAPS + 2; n++) begin
         send(1);
         if (n == 10) chk("step_n10", fir_out, 55);
      end
      chk("step_steady", fir_out, STEP_POS);

      // Tap 70 is read last, so a write at k=10 lands on the in-flight sample.
      coef_m[70] = 0;
      send_nowait(1);
      repeat (10) step();
      coeff_write = 1'b1; coeff_addr = 7'd70; coeff_in = '0;
      step();
      coeff_write = 1'b0;
      wait_out();
      chk("hazard_mid_mac", fir_out, HAZ_EXP);

      // Write coinciding with the read of tap 70: this sample keeps the old value.
      send_nowait(1);
      repeat (70) step();
      coeff_write = 1'b1; coeff_addr = 7'd70; coeff_in = 8'sd70;
      step();
      coeff_write = 1'b0;
      coef_m[70] = 70;
      wait_out();
      chk("hazard_same_cycle", fir_out, HAZ_EXP);

      wcoef(100, 55);
      send(1);
      chk("addr_out_of_range", fir_out, STEP_POS);

      for (int n = 0; n < NUM_TAPS + 2; n++) send(-1);
      chk("neg_step_steady", fir_out, STEP_NEG);

      acc_cyc.delete();
      rdy = 0;
      sample_in = -4'sd1;
      in_valid = 1'b1;
      for (int i = 0; i < 4 * PERIOD && acc_cyc.size() < 3; i++) begin
         if (in_ready === 1'b1) rdy++;
         step();
      end
      in_valid = 1'b0;
      wait_out();
      chk("hs_accepts", acc_cyc.size(), 3);
      if (acc_cyc.size() == 3) begin
         chk("hs_period_1", acc_cyc[1] - acc_cyc[0], PERIOD);
         chk("hs_period_2", acc_cyc[2] - acc_cyc[1], PERIOD);
      end
      chk("hs_ready_cycles", rdy, 3);

      send_nowait(1);
      repeat (20) step();
      #2 rst = 1'b1;
      #1;
      chk("amid_rst_fir_out", fir_out, 0);
      chk("amid_rst_out_valid", {31'b0, out_valid}, 0);
      chk("amid_rst_in_ready", {31'b0, in_ready}, 1);
      exp_q.delete();
      lat_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (PERIOD + 5) step();
      send(1);
      chk("post_rst_impulse0", fir_out, 0);
      for (int n = 0; n < 5; n++) send(0);
      chk("post_rst_impulse5", fir_out, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
